// File: rtl/seg_display_scanner.sv
`default_nettype none
// ==== seg_display_scanner : multiplexed 7-seg driver, hex or binary-to-BCD (macro SEG_BCD_EN) ====
// ==== Revision 1.0                                                                            ====
module seg_display_scanner #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic                    val_valid_in,
  output logic                    val_ready_out,
  input  logic                    dec_mode_in,
  input  logic                    blank_lz_in,
  output logic [6:0]              cat_out,
  output logic [NUM_DIGITS-1:0]   an_out
);

  localparam int W     = 4 * NUM_DIGITS;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_DASH  = 7'b0111111;
  localparam logic [6:0]       SEG_BLANK = 7'b1111111;

  logic [W-1:0]          disp_q, disp_d;
  logic                  ovf_q, ovf_d;
  logic                  accept_w;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            cat_q;
  logic [W-1:0]          upper_w;
  logic [3:0]            digit_w;
  logic                  blank_w;
  logic [6:0]            seg_w;

  assign accept_w = val_valid_in & val_ready_out;

`ifdef SEG_BCD_EN
  localparam int BC_W = $clog2(W);
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_CONVERT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [W-1:0]  sh_q, bcd_q, bcd_adj_w, bcd_next_w;
  logic          ovf_acc_q, ovf_next_w;
  logic [BC_W-1:0] bit_q;
  logic          conv_done_w;

  // Double-dabble: add 3 to every BCD digit >= 5, then shift in the next binary bit.
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dabble
    assign bcd_adj_w[4*d +: 4] = (bcd_q[4*d +: 4] >= 4'd5) ? (bcd_q[4*d +: 4] + 4'd3)
                                                            : bcd_q[4*d +: 4];
  end

  assign bcd_next_w  = {bcd_adj_w[W-2:0], sh_q[W-1]};
  assign ovf_next_w  = ovf_acc_q | bcd_adj_w[W-1];
  assign conv_done_w = (bit_q == BC_W'(W - 1));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept_w && dec_mode_in) state_d = ST_CONVERT;
      ST_CONVERT: if (conv_done_w)             state_d = ST_IDLE;
      default:                                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    val_ready_out = (state_q == ST_IDLE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sh_q      <= '0;
      bcd_q     <= '0;
      ovf_acc_q <= 1'b0;
      bit_q     <= '0;
    end else if (state_q == ST_IDLE) begin
      if (accept_w) begin
        sh_q      <= val_in;
        bcd_q     <= '0;
        ovf_acc_q <= 1'b0;
        bit_q     <= '0;
      end
    end else begin
      sh_q      <= {sh_q[W-2:0], 1'b0};
      bcd_q     <= bcd_next_w;
      ovf_acc_q <= ovf_next_w;
      bit_q     <= bit_q + BC_W'(1);
    end
  end

  always_comb begin
    disp_d = disp_q;
    ovf_d  = ovf_q;
    if (accept_w && !dec_mode_in) begin
      disp_d = val_in;
      ovf_d  = 1'b0;
    end else if ((state_q == ST_CONVERT) && conv_done_w) begin
      disp_d = bcd_next_w;
      ovf_d  = ovf_next_w;
    end
  end
`else
  logic unused_dec_mode;
  assign unused_dec_mode = dec_mode_in;
  assign val_ready_out   = 1'b1;

  always_comb begin
    disp_d = disp_q;
    ovf_d  = 1'b0;
    if (accept_w) disp_d = val_in;
  end
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      disp_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      disp_q <= disp_d;
      ovf_q  <= ovf_d;
    end
  end

  // A digit is a leading zero when it and everything above it is zero.
  assign upper_w = disp_q >> {idx_q, 2'b00};
  assign digit_w = upper_w[3:0];
  assign blank_w = blank_lz_in && (idx_q != '0) && (upper_w == '0);

  always_comb begin
    seg_w = SEG_BLANK;
    case (digit_w)
      4'h0: seg_w = 7'b1000000;
      4'h1: seg_w = 7'b1111001;
      4'h2: seg_w = 7'b0100100;
      4'h3: seg_w = 7'b0110000;
      4'h4: seg_w = 7'b0011001;
      4'h5: seg_w = 7'b0010010;
      4'h6: seg_w = 7'b0000010;
      4'h7: seg_w = 7'b1111000;
      4'h8: seg_w = 7'b0000000;
      4'h9: seg_w = 7'b0010000;
      4'hA: seg_w = 7'b0001000;
      4'hB: seg_w = 7'b0000011;
      4'hC: seg_w = 7'b1000110;
      4'hD: seg_w = 7'b0100001;
      4'hE: seg_w = 7'b0000110;
      4'hF: seg_w = 7'b0001110;
      default: seg_w = SEG_BLANK;
    endcase
    if (ovf_q)        seg_w = SEG_DASH;
    else if (blank_w) seg_w = SEG_BLANK;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= '1;
      cat_q <= SEG_BLANK;
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        idx_q <= (idx_q == IDX_LAST) ? '0 : (idx_q + IDX_W'(1));
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      an_q  <= ~(NUM_DIGITS'(1) << idx_q);
      cat_q <= seg_w;
    end
  end

  assign an_out  = an_q;
  assign cat_out = cat_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scanner.sv
`default_nettype none
// Bench for seg_display_scanner: random hex/decimal values checked against a digit-level model.
module tb_seg_display_scanner;
  localparam int ND = 8;
  localparam int RD = 4;
`ifdef SEG_BCD_EN
  localparam bit BCD_ON = 1'b1;
`else
  localparam bit BCD_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4*ND-1:0] val = '0;
  logic          valid = 1'b0;
  logic          ready;
  logic          dec_mode = 1'b0;
  logic          blank_lz = 1'b0;
  logic [6:0]    cat;
  logic [ND-1:0] an;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_val = '0;
  bit          m_dec = 1'b0;
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_display_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .val_in       (val),
    .val_valid_in (valid),
    .val_ready_out(ready),
    .dec_mode_in  (dec_mode),
    .blank_lz_in  (blank_lz),
    .cat_out      (cat),
    .an_out       (an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input int k, input bit blank);
    int     dig [ND];
    longint v;
    longint p;
    bit     all_zero;
    v = longint'(m_val);
    p = 1;
    for (int j = 0; j < ND; j++) begin
      if (m_dec) dig[j] = int'((v / p) % 10);
      else       dig[j] = int'((v >> (4 * j)) & 15);
      p = p * 10;
    end
    if (m_dec && v >= p) return 7'b0111111;
    if (blank && k != 0) begin
      all_zero = 1'b1;
      for (int j = k; j < ND; j++) if (dig[j] != 0) all_zero = 1'b0;
      if (all_zero) return 7'b1111111;
    end
    return seg_tab[dig[k]];
  endfunction

  task automatic model_set(input logic [31:0] v, input bit dec);
    m_val = v;
    m_dec = BCD_ON && dec;
  endtask

  task automatic offer(input logic [31:0] v, input bit dec);
    @(negedge clk);
    val = v; dec_mode = dec; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic measure_busy(input int want, input string name);
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (ready === 1'b1) break;
      n++;
    end
    total++;
    if (n !== want) begin
      bad++;
      $display("FAIL %s busy cycles got %0d want %0d", name, n, want);
    end
  endtask

  task automatic check_display(input string name);
    int k;
    logic [ND-1:0] one;
    logic [6:0] e;
    one = 1;
    repeat (2) @(posedge clk);
    for (int c = 0; c < ND * RD; c++) begin
      @(negedge clk);
      k = -1;
      for (int j = 0; j < ND; j++) if (an === ~(one << j)) k = j;
      total++;
      if (k < 0) begin
        bad++;
        $display("FAIL %s an_out not one-hot-low: got %b", name, an);
      end else begin
        e = exp_seg(k, blank_lz);
        total++;
        if (cat !== e) begin
          bad++;
          $display("FAIL %s digit %0d cat_out got %b want %b (val %h dec %0d)",
                   name, k, cat, e, m_val, m_dec);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if (an !== '1) begin bad++; $display("FAIL %s an_out got %b want all ones", name, an); end
    total++;
    if (cat !== 7'h7F) begin bad++; $display("FAIL %s cat_out got %b want 1111111", name, cat); end
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL %s val_ready_out got %b want 1", name, ready); end
  endtask

  task automatic test_reset();
    logic [ND-1:0] one;
    logic [ND-1:0] e;
    one = 1;
    blank_lz = 1'b0;
    repeat (3) @(posedge clk);
    #2 check_reset_outputs("reset_hold");
    @(negedge clk);
    rst = 1'b0;
    model_set(32'h0, 1'b0);
    for (int n = 1; n <= ND * RD + 4; n++) begin
      @(negedge clk);
      e = ~(one << (((n - 1) / RD) % ND));
      total++;
      if (an !== e) begin
        bad++;
        $display("FAIL scan_seq cycle %0d an_out got %b want %b", n, an, e);
      end
      total++;
      if (cat !== seg_tab[0]) begin
        bad++;
        $display("FAIL scan_zero cycle %0d cat_out got %b want %b", n, cat, seg_tab[0]);
      end
    end
  endtask

  task automatic test_hex_blank();
    blank_lz = 1'b1;
    offer(32'h0000ABCF, 1'b0);
    model_set(32'h0000ABCF, 1'b0);
    measure_busy(0, "hex_abcf_ready");
    check_display("hex_abcf_blank");
  endtask

  task automatic test_hex_random();
    logic [31:0] v;
    for (int i = 0; i < 4; i++) begin
      v = $urandom >> (4 * $urandom_range(0, 7));
      blank_lz = 1'($urandom_range(0, 1));
      offer(v, 1'b0);
      model_set(v, 1'b0);
      measure_busy(0, "hex_rand_ready");
      check_display("hex_rand");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v1, v2;
    v1 = $urandom;
    v2 = $urandom >> 8;
    blank_lz = 1'b1;
    @(negedge clk);
    val = v1; dec_mode = 1'b0; valid = 1'b1;
    @(negedge clk);
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL b2b ready after hex got %b want 1", ready); end
    val = v2;
    @(posedge clk);
    #1 valid = 1'b0;
    val = $urandom;
    model_set(v2, 1'b0);
    check_display("hex_back_to_back");
  endtask

  task automatic test_decimal();
    blank_lz = 1'b0;
    offer(32'h000000E0, 1'b1);
    model_set(32'h000000E0, 1'b1);
    measure_busy(BCD_ON ? ND * 4 : 0, "dec_224_busy");
    check_display("dec_224");
    blank_lz = 1'b1;
    offer(32'hFFFFFFFF, 1'b1);
    model_set(32'hFFFFFFFF, 1'b1);
    measure_busy(BCD_ON ? ND * 4 : 0, "dec_ovf_busy");
    check_display("dec_overflow");
  endtask

  task automatic test_decimal_random();
    logic [31:0] v;
    for (int i = 0; i < 4; i++) begin
      v = (i == 3) ? $urandom : $urandom_range(0, 99999999);
      blank_lz = 1'($urandom_range(0, 1));
      offer(v, 1'b1);
      model_set(v, 1'b1);
      measure_busy(BCD_ON ? ND * 4 : 0, "dec_rand_busy");
      check_display("dec_rand");
    end
  endtask

  task automatic test_ignore_mid_convert();
    blank_lz = 1'b0;
    offer(32'h00001234, 1'b1);
    model_set(32'h00001234, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    val = 32'h00009999; dec_mode = 1'b0; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    if (!BCD_ON) model_set(32'h00009999, 1'b0);
    repeat (40) @(posedge clk);
    check_display("ignore_mid_convert");
  endtask

  task automatic test_reset_mid_convert();
    blank_lz = 1'b0;
    offer(32'h00123456, 1'b1);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs("reset_mid_convert");
    @(negedge clk);
    rst = 1'b0;
    model_set(32'h0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL post_reset ready got %b want 1", ready); end
    check_display("post_reset_zero");
  endtask

  initial begin
    test_reset();
    test_hex_blank();
    test_hex_random();
    test_back_to_back();
    test_decimal();
    test_decimal_random();
    test_ignore_mid_convert();
    test_reset_mid_convert();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
